// File: rtl/uart_rx_param.sv
// UART receiver, parameterised data width, 3-sample majority voting,
// optional parity, one or two stop bits, break and overrun detection.
//
// Ports:
//   clk, rst        : single clock, asynchronous active-high reset
//   RX_IN           : serial line (idle high, asynchronous to clk)
//   prescale        : clk cycles per bit, latched at start of frame
//   PAR_EN, PAR_TYP : parity enable, 0 = even / 1 = odd
//   TWO_STOP        : 1 = two stop bits
//   rx_ready        : consumer accepts the presented word
//   P_DATA          : received word, LSB first on the line
//   data_valid      : P_DATA and error flags valid, held until accepted
//   parity_error    : parity mismatch for the presented word
//   stop_error      : a stop bit was sampled low for the presented word
//   overrun_error   : one-cycle pulse, frame lost because word not taken
//   break_det       : one-cycle pulse, break condition seen
//   busy            : receiver not idle
module uart_rx_param #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  TWO_STOP,
    input  logic                  rx_ready,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  overrun_error,
    output logic                  break_det,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int BIT_W = 4;
    localparam logic [PRESCALE_W-1:0] ONE = 1;

    state_t state_q, state_d;

    logic sync1_q, sync2_q;
    logic line;

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [PRESCALE_W-1:0] ps_q, ps_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [1:0]            vote_q, vote_d;
    logic [DATA_W-1:0]     shift_q, shift_d;

    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic two_stop_q, two_stop_d;
    logic par_bit_q, par_bit_d;
    logic stop_low_q, stop_low_d;

    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic dv_q, dv_d;
    logic perr_q, perr_d;
    logic serr_q, serr_d;
    logic ovr_q, ovr_d;
    logic brk_q, brk_d;

    logic [PRESCALE_W-1:0] mid, mid_m1, mid_p1, last;
    logic [1:0] vote_sum;
    logic       maj;
    logic       at_mid_p1, at_last, sampling;
    logic       done;
    logic       stop_bad, is_brk;

    assign line = sync2_q;

    // Sample points around the bit centre; the third sample is used
    // combinationally together with the two already counted.
    assign mid       = ps_q >> 1;
    assign mid_m1    = mid - ONE;
    assign mid_p1    = mid + ONE;
    assign last      = ps_q - ONE;
    assign at_mid_p1 = (edge_q == mid_p1);
    assign at_last   = (edge_q == last);
    assign sampling  = (edge_q == mid_m1) || (edge_q == mid);
    assign vote_sum  = vote_q + {1'b0, line};
    assign maj       = vote_sum[1];

    assign stop_bad = stop_low_q | ~maj;
    assign is_brk   = (shift_q == '0)
                   && (!par_en_q || !par_bit_q)
                   && !maj
                   && (!two_stop_q || stop_low_q);

    always_comb begin
        state_d    = state_q;
        edge_d     = at_last ? '0 : edge_q + ONE;
        bit_d      = at_last ? bit_q + 1'b1 : bit_q;
        vote_d     = at_last ? 2'd0 : (sampling ? vote_sum : vote_q);
        ps_d       = ps_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        two_stop_d = two_stop_q;
        par_bit_d  = par_bit_q;
        stop_low_d = stop_low_q;
        p_data_d   = p_data_q;
        dv_d       = dv_q & ~rx_ready;
        perr_d     = perr_q;
        serr_d     = serr_q;
        ovr_d      = 1'b0;
        brk_d      = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                vote_d = 2'd0;
                if (!line) begin
                    state_d    = START;
                    ps_d       = prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    two_stop_d = TWO_STOP;
                    stop_low_d = 1'b0;
                    par_bit_d  = 1'b0;
                end
            end
            START: begin
                // Glitch check wins when mid+1 and the last edge coincide.
                if (at_mid_p1 && maj) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                    vote_d  = 2'd0;
                end else if (at_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (at_mid_p1) begin
                    shift_d = {maj, shift_q[DATA_W-1:1]};
                end
                if (at_last && bit_q == BIT_W'(DATA_W - 1)) begin
                    state_d = par_en_q ? PARITY : STOP;
                    bit_d   = '0;
                end
            end
            PARITY: begin
                if (at_mid_p1) begin
                    par_bit_d = maj;
                end
                if (at_last) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (at_mid_p1) begin
                    if (two_stop_q && bit_q == '0) begin
                        stop_low_d = ~maj;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                vote_d = 2'd0;
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
                vote_d  = 2'd0;
            end
        endcase

        // Frame completes mid final stop bit so a following start
        // edge is not missed.
        if (done) begin
            edge_d = '0;
            bit_d  = '0;
            vote_d = 2'd0;
            if (is_brk) begin
                brk_d   = 1'b1;
                state_d = WAIT_IDLE;
            end else begin
                state_d = stop_bad ? WAIT_IDLE : IDLE;
                if (dv_q && !rx_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    p_data_d = shift_q;
                    perr_d   = par_en_q
                            && ((^shift_q ^ par_bit_q) != par_typ_q);
                    serr_d   = stop_bad;
                    dv_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            vote_q     <= 2'd0;
            ps_q       <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_low_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync1_q    <= RX_IN;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            vote_q     <= vote_d;
            ps_q       <= ps_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            two_stop_q <= two_stop_d;
            par_bit_q  <= par_bit_d;
            stop_low_q <= stop_low_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign P_DATA        = p_data_q;
    assign data_valid    = dv_q;
    assign parity_error  = perr_q;
    assign stop_error    = serr_q;
    assign overrun_error = ovr_q;
    assign break_det     = brk_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: table of frames at DATA_W=8 plus
// directed glitch, overrun, break and reset-abort sequences.
module tb_uart_rx_param;

    logic       clk;
    logic       rst, rst5;
    logic       RX_IN, RX_IN5;
    logic [5:0] prescale;
    logic       PAR_EN, PAR_TYP, TWO_STOP, rx_ready;

    logic [7:0] P_DATA;
    logic       data_valid, parity_error, stop_error;
    logic       overrun_error, break_det, busy;

    logic [4:0] P_DATA5;
    logic       dv5, perr5, serr5, ovr5, brk5, busy5;

    uart_rx_param #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TWO_STOP(TWO_STOP),
        .rx_ready(rx_ready), .P_DATA(P_DATA), .data_valid(data_valid),
        .parity_error(parity_error), .stop_error(stop_error),
        .overrun_error(overrun_error), .break_det(break_det),
        .busy(busy)
    );

    uart_rx_param #(.DATA_W(5), .PRESCALE_W(6)) dut5 (
        .clk(clk), .rst(rst5), .RX_IN(RX_IN5), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TWO_STOP(TWO_STOP),
        .rx_ready(rx_ready), .P_DATA(P_DATA5), .data_valid(dv5),
        .parity_error(perr5), .stop_error(serr5),
        .overrun_error(ovr5), .break_det(brk5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         ps;
        logic       par_en;
        logic       par_typ;
        logic       pbit;
        logic       two_stop;
        logic       stop0;
        logic       stop1;
        logic       chg_ps;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[11];

    int n_chk, n_fail;
    int dv_rise, dv_cyc, ovr_cnt, brk_cnt, busy_cyc;
    int dv5_rise, ovr5_cnt, brk5_cnt;
    logic dv_prev, dv5_prev;
    logic [7:0] cap_data;
    logic cap_perr, cap_serr;
    logic [4:0] cap5_data;
    logic cap5_perr, cap5_serr;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (data_valid && !dv_prev) begin
            dv_rise++;
            cap_data = P_DATA;
            cap_perr = parity_error;
            cap_serr = stop_error;
        end
        if (data_valid) dv_cyc++;
        dv_prev = data_valid;
        if (overrun_error) ovr_cnt++;
        if (break_det) brk_cnt++;
        if (busy) busy_cyc++;
        if (dv5 && !dv5_prev) begin
            dv5_rise++;
            cap5_data = P_DATA5;
            cap5_perr = perr5;
            cap5_serr = serr5;
        end
        dv5_prev = dv5;
        if (ovr5) ovr5_cnt++;
        if (brk5) brk5_cnt++;
    endtask

    task automatic clr();
        dv_rise = 0; dv_cyc = 0; ovr_cnt = 0; brk_cnt = 0; busy_cyc = 0;
        dv5_rise = 0; ovr5_cnt = 0; brk5_cnt = 0;
        cap_data = '0; cap_perr = 1'b0; cap_serr = 1'b0;
        cap5_data = '0; cap5_perr = 1'b0; cap5_serr = 1'b0;
    endtask

    task automatic hold(input int sel, input logic v, input int n);
        if (sel == 0) RX_IN = v;
        else RX_IN5 = v;
        repeat (n) tick();
    endtask

    task automatic send(input int sel, input logic [7:0] d,
                        input int nbits, input int ps, input logic pen,
                        input logic pbit, input logic two,
                        input logic s0, input logic s1,
                        input logic chg);
        hold(sel, 1'b0, ps);
        if (chg) prescale = 6'd20;
        for (int i = 0; i < nbits; i++) hold(sel, d[i], ps);
        if (pen) hold(sel, pbit, ps);
        hold(sel, s0, ps);
        if (two) hold(sel, s1, ps);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        dv_prev = 1'b0; dv5_prev = 1'b0;
        clr();
        //            data  ps pen typ pb two s0 s1 chg perr serr
        vecs[0]  = '{8'hA5,  8, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{8'h07,  8, 1, 0, 0, 0, 1, 1, 0, 1, 0};
        vecs[2]  = '{8'h07,  8, 1, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[3]  = '{8'h3C,  8, 1, 1, 1, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{8'h55,  8, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{8'hFF,  8, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[6]  = '{8'h81,  8, 0, 0, 0, 1, 0, 1, 0, 0, 1};
        vecs[7]  = '{8'h00,  8, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[8]  = '{8'hC3,  4, 1, 1, 0, 0, 1, 1, 0, 1, 0};
        vecs[9]  = '{8'h5A, 63, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[10] = '{8'h96,  8, 0, 0, 0, 0, 1, 1, 1, 0, 0};

        rst = 1'b1; rst5 = 1'b1;
        RX_IN = 1'b1; RX_IN5 = 1'b1;
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        TWO_STOP = 1'b0; rx_ready = 1'b1;
        repeat (3) tick();
        chk("rst_p_data", int'(P_DATA), 0);
        chk("rst_flags", int'({data_valid, parity_error, stop_error,
                              overrun_error, break_det, busy}), 0);
        rst = 1'b0; rst5 = 1'b0;
        repeat (4) tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_dv", int'(data_valid), 0);

        for (int v = 0; v < 11; v++) begin
            prescale = 6'(vecs[v].ps);
            PAR_EN   = vecs[v].par_en;
            PAR_TYP  = vecs[v].par_typ;
            TWO_STOP = vecs[v].two_stop;
            clr();
            send(0, vecs[v].data, 8, vecs[v].ps, vecs[v].par_en,
                 vecs[v].pbit, vecs[v].two_stop, vecs[v].stop0,
                 vecs[v].stop1, vecs[v].chg_ps);
            hold(0, 1'b1, 2 * vecs[v].ps + 4);
            chk($sformatf("v%0d_dv_rise", v), dv_rise, 1);
            chk($sformatf("v%0d_dv_cyc", v), dv_cyc, 1);
            chk($sformatf("v%0d_data", v), int'(cap_data),
                int'(vecs[v].data));
            chk($sformatf("v%0d_perr", v), int'(cap_perr),
                int'(vecs[v].exp_perr));
            chk($sformatf("v%0d_serr", v), int'(cap_serr),
                int'(vecs[v].exp_serr));
            chk($sformatf("v%0d_pulses", v), ovr_cnt + brk_cnt, 0);
            chk($sformatf("v%0d_busy", v), int'(busy), 0);
        end

        // Short low glitch must be rejected.
        prescale = 6'd8; PAR_EN = 1'b0; TWO_STOP = 1'b0;
        clr();
        hold(0, 1'b0, 2);
        hold(0, 1'b1, 16);
        n_chk++;
        if (!(busy_cyc >= 1 && busy_cyc <= 8)) begin
            n_fail++;
            $display("FAIL glitch_busy_len: got %0d expected 1..8",
                     busy_cyc);
        end
        chk("glitch_dv", dv_rise, 0);
        chk("glitch_busy_end", int'(busy), 0);

        // Overrun: second word completes while first is held.
        rx_ready = 1'b0;
        clr();
        send(0, 8'h11, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(0, 8'h22, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(0, 1'b1, 20);
        chk("ovr_cap", int'(cap_data), 8'h11);
        chk("ovr_hold_data", int'(P_DATA), 8'h11);
        chk("ovr_hold_dv", int'(data_valid), 1);
        chk("ovr_dv_rise", dv_rise, 1);
        chk("ovr_pulses", ovr_cnt, 1);
        rx_ready = 1'b1;
        tick();
        chk("ovr_accept_dv", int'(data_valid), 0);

        // Break: line low for 12 bit-times with two stop bits.
        TWO_STOP = 1'b1;
        clr();
        hold(0, 1'b0, 96);
        hold(0, 1'b1, 24);
        chk("brk_pulses", brk_cnt, 1);
        chk("brk_dv", dv_rise, 0);
        chk("brk_busy", int'(busy), 0);
        clr();
        send(0, 8'h3C, 8, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(0, 1'b1, 20);
        chk("brk_next_dv", dv_rise, 1);
        chk("brk_next_data", int'(cap_data), 8'h3C);
        chk("brk_next_serr", int'(cap_serr), 0);

        // DATA_W=5: reset mid data bit 2 aborts the frame.
        prescale = 6'd16; PAR_EN = 1'b0; TWO_STOP = 1'b0;
        clr();
        hold(1, 1'b0, 16);
        hold(1, 1'b1, 16);
        hold(1, 1'b0, 16);
        hold(1, 1'b1, 8);
        rst5 = 1'b1;
        RX_IN5 = 1'b1;
        tick();
        chk("w5_rst_data", int'(P_DATA5), 0);
        chk("w5_rst_flags", int'({dv5, perr5, serr5, ovr5, brk5, busy5}), 0);
        tick();
        rst5 = 1'b0;
        hold(1, 1'b1, 48);
        chk("w5_abort_dv", dv5_rise, 0);
        chk("w5_abort_pulses", ovr5_cnt + brk5_cnt, 0);
        chk("w5_abort_busy", int'(busy5), 0);
        clr();
        send(1, 8'h1F, 5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1, 1'b1, 36);
        chk("w5_dv", dv5_rise, 1);
        chk("w5_data", int'(cap5_data), 5'h1F);
        chk("w5_flags", int'({cap5_perr, cap5_serr}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame; legal 5..9.
REQ-002 Parameter PRESCALE_W, default 6, width of the prescale input.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 RX_IN  input  1  serial line, idle high, asynchronous to clk.
REQ-007 prescale  input  PRESCALE_W  clk cycles per bit; legal 4..2^PRESCALE_W-1.
REQ-008 PAR_EN  input  1  1 = parity bit present after data.
REQ-009 PAR_TYP  input  1  0 = even, 1 = odd.
REQ-010 TWO_STOP  input  1  1 = two stop bits, 0 = one.
REQ-011 rx_ready  input  1  consumer accepts p_data when high with data_valid.
REQ-012 P_DATA  output  DATA_W  received word, LSB = first data bit on line.
REQ-013 data_valid  output  1  P_DATA and error flags valid; held until accepted.
REQ-014 parity_error  output  1  parity mismatch for the presented word.
REQ-015 stop_error  output  1  any stop bit sampled low for the presented word.
REQ-016 overrun_error  output  1  one-cycle pulse: frame lost, previous word not accepted.
REQ-017 break_det  output  1  one-cycle pulse: break condition detected.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 RX_IN SHALL pass a 2-flop synchroniser (reset value 1) before any use; all line references below mean the synchronised value.
REQ-020 States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-021 IDLE->START on synchronised line low; prescale, PAR_EN, PAR_TYP, TWO_STOP SHALL be latched at this transition; changes mid-frame are ignored.
REQ-022 Edge counter counts 0..prescale_l-1 per bit, then wraps to 0 and increments bit counter; both cleared on IDLE entry.
REQ-023 Each bit value SHALL be majority-of-3 of samples at edge_cnt = mid-1, mid, mid+1, mid = prescale_l>>1 (integer).
REQ-024 START: if the start majority is 1 -> IDLE (glitch, no outputs change); else DATA at edge_cnt = prescale_l-1.
REQ-025 DATA: DATA_W bits shifted LSB-first; after the last data bit -> PARITY if PAR_EN else STOP.
REQ-026 PARITY: error if XOR(data,parity bit) != PAR_TYP.
REQ-027 STOP: one or two stop bits; the final stop bit is decided at edge_cnt = mid+1 (frame completes mid-bit so back-to-back frames are not missed).
REQ-028 On completion with all stop bits 1 -> IDLE; with any stop bit 0 -> WAIT_IDLE, which returns to IDLE only after the line is sampled high.
REQ-029 Break: all data bits 0, parity bit (if enabled) 0, and stop bit 0 -> break_det pulses one cycle, no word delivered, -> WAIT_IDLE.
REQ-030 Delivery: on non-break completion, P_DATA/parity_error/stop_error SHALL update and data_valid rise one cycle after the completion cycle.
REQ-031 data_valid SHALL stay high with outputs stable until a cycle with rx_ready=1; it drops the next cycle unless a new word is delivered the same cycle (then stays high with new word).
REQ-032 If a word completes while data_valid=1 and rx_ready=0, the new word SHALL be discarded, the held word is kept, and overrun_error pulses one cycle.
REQ-033 Words with parity_error or stop_error SHALL still be delivered; flags qualify them.

Reset
REQ-034 On rst: state IDLE, counters 0, P_DATA 0, data_valid/parity_error/stop_error/overrun_error/break_det/busy 0, synchroniser 1.
REQ-035 rst mid-frame SHALL abort the frame immediately with no word or pulse delivered after release.

Verification
REQ-036 DATA_W=8, prescale=8, no parity, 1 stop, send 0xA5, rx_ready=1 -> P_DATA=0xA5, data_valid one cycle, no errors.
REQ-037 PAR_EN=1, PAR_TYP=0, send 0x07 with parity bit 0 -> P_DATA=0x07, parity_error=1, data_valid=1.
REQ-038 Low pulse of 2 cycles at prescale=8 -> return to IDLE, no data_valid, busy low again within 8 cycles.
REQ-039 rx_ready=0, send 0x11 then 0x22 back-to-back -> P_DATA holds 0x11, overrun_error one pulse; rx_ready=1 then clears data_valid.
REQ-040 Line held low 12 bit-times, TWO_STOP=1 -> one break_det pulse, no data_valid, next frame 0x3C received after line returns high.
REQ-041 DATA_W=5, prescale=16, rst asserted mid-data-bit 2 -> all outputs 0; next frame 0x1F received correctly.
